// File: rtl/lc3_pkg.sv
// rtl/lc3_pkg.sv - LC-3 core shared types, constants and decode helpers
package lc3_pkg;

    localparam int WORD_W = 16;
    localparam logic [2:0] CC_RESET = 3'b010;

    typedef enum logic [3:0] {
        OP_BR   = 4'b0000,
        OP_ADD  = 4'b0001,
        OP_LD   = 4'b0010,
        OP_ST   = 4'b0011,
        OP_JSR  = 4'b0100,
        OP_AND  = 4'b0101,
        OP_LDR  = 4'b0110,
        OP_STR  = 4'b0111,
        OP_RTI  = 4'b1000,
        OP_NOT  = 4'b1001,
        OP_LDI  = 4'b1010,
        OP_STI  = 4'b1011,
        OP_JMP  = 4'b1100,
        OP_RES  = 4'b1101,
        OP_LEA  = 4'b1110,
        OP_TRAP = 4'b1111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_EXEC  = 2'd1,
        ST_IND   = 2'd2,
        ST_MEM   = 2'd3
    } state_e;

    // NZP flags of a written result: exactly one bit set
    function automatic logic [2:0] cc_from(input logic [WORD_W-1:0] v);
        logic [2:0] cc;
        if (v[WORD_W-1]) begin
            cc = 3'b100;
        end else if (v == '0) begin
            cc = 3'b010;
        end else begin
            cc = 3'b001;
        end
        return cc;
    endfunction

    // Instructions that need a data-memory cycle after EXEC
    function automatic logic is_mem_op(input opcode_e op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI) ||
               (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    // Instructions whose effective address is fetched through a pointer
    function automatic logic is_ind_op(input opcode_e op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

    function automatic logic is_store(input opcode_e op);
        return (op == OP_ST) || (op == OP_STR) || (op == OP_STI);
    endfunction

    function automatic logic is_load(input opcode_e op);
        return (op == OP_LD) || (op == OP_LDR) || (op == OP_LDI);
    endfunction

endpackage

// File: rtl/lc3_regfile.sv
// rtl/lc3_regfile.sv - LC-3 8x16 register file, two async reads, debug read, one sync write
module lc3_regfile
    import lc3_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic [2:0]        waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [2:0]        raddr_a_i,
    output logic [WORD_W-1:0] rdata_a_o,
    input  logic [2:0]        raddr_b_i,
    output logic [WORD_W-1:0] rdata_b_o,
    input  logic [2:0]        dbg_sel_i,
    output logic [WORD_W-1:0] dbg_rdata_o
);

    logic [WORD_W-1:0] regs_q [8];

    // Single write port; whole array cleared by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o   = regs_q[raddr_a_i];
    assign rdata_b_o   = regs_q[raddr_b_i];
    assign dbg_rdata_o = regs_q[dbg_sel_i];

endmodule

// File: rtl/lc3_control.sv
// rtl/lc3_control.sv - multicycle LC-3 core (FETCH/EXEC/IND/MEM), optional halt on TRAP x25 via LC3_TRAP_HALT_EN
module lc3_control
    import lc3_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic [WORD_W-1:0] mem_addr,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              instr_done,
    output logic [WORD_W-1:0] pc_o,
    output logic [WORD_W-1:0] ir_o,
    output logic [2:0]        cc_o,
    input  logic [2:0]        dbg_sel,
    output logic [WORD_W-1:0] dbg_reg,
    output logic              halted
);

    state_e            state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic [WORD_W-1:0] mar_q, mar_d;
    logic [2:0]        cc_q, cc_d;
    logic              mem_we_q, mem_we_d;
    logic              done_q, done_d;
    logic              halt_q, halt_d;

    logic              rf_we;
    logic [2:0]        rf_waddr;
    logic [WORD_W-1:0] rf_wdata;
    logic [2:0]        rf_raddr_b;
    logic [WORD_W-1:0] rf_a, rf_b;
    logic              set_cc;

    opcode_e           op, fetch_op;
    logic [WORD_W-1:0] off6, off9, off11, imm5;
    logic [WORD_W-1:0] alu_b, pc_off9, trap_addr;
    logic              trap_halt;

    assign op       = opcode_e'(ir_q[15:12]);
    assign fetch_op = opcode_e'(mem_rdata[15:12]);

    assign off6      = {{10{ir_q[5]}}, ir_q[5:0]};
    assign off9      = {{7{ir_q[8]}}, ir_q[8:0]};
    assign off11     = {{5{ir_q[10]}}, ir_q[10:0]};
    assign imm5      = {{11{ir_q[4]}}, ir_q[4:0]};
    assign alu_b     = ir_q[5] ? imm5 : rf_b;
    assign pc_off9   = pc_q + off9;
    assign trap_addr = {8'h00, ir_q[7:0]};

`ifdef LC3_TRAP_HALT_EN
    assign trap_halt = (ir_q[7:0] == 8'h25);
    assign halted    = halt_q;
`else
    assign trap_halt = 1'b0;
    assign halted    = 1'b0;
`endif

    // Second read port serves SR2 during EXEC and the store source afterwards
    assign rf_raddr_b = (state_q == ST_EXEC) ? ir_q[2:0] : ir_q[11:9];

    lc3_regfile u_regfile (
        .clk         (clk),
        .rst_n       (rst_n),
        .we_i        (rf_we),
        .waddr_i     (rf_waddr),
        .wdata_i     (rf_wdata),
        .raddr_a_i   (ir_q[8:6]),
        .rdata_a_o   (rf_a),
        .raddr_b_i   (rf_raddr_b),
        .rdata_b_o   (rf_b),
        .dbg_sel_i   (dbg_sel),
        .dbg_rdata_o (dbg_reg)
    );

    // Next-state, datapath updates, memory address and register write for this cycle
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        mar_d    = mar_q;
        cc_d     = cc_q;
        halt_d   = halt_q;
        mem_we_d = 1'b0;
        done_d   = 1'b0;
        mem_addr = pc_q;
        rf_we    = 1'b0;
        rf_waddr = ir_q[11:9];
        rf_wdata = '0;
        set_cc   = 1'b0;

        unique case (state_q)
            ST_FETCH: begin
                if (!halt_q) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_EXEC;
                    // instr_done is registered, so flag single-step instructions now
                    done_d  = !is_mem_op(fetch_op);
                end
            end

            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_ADD: begin
                        rf_we    = 1'b1;
                        rf_wdata = rf_a + alu_b;
                        set_cc   = 1'b1;
                    end
                    OP_AND: begin
                        rf_we    = 1'b1;
                        rf_wdata = rf_a & alu_b;
                        set_cc   = 1'b1;
                    end
                    OP_NOT: begin
                        rf_we    = 1'b1;
                        rf_wdata = ~rf_a;
                        set_cc   = 1'b1;
                    end
                    OP_LEA: begin
                        rf_we    = 1'b1;
                        rf_wdata = pc_off9;
                        set_cc   = 1'b1;
                    end
                    OP_BR: begin
                        if ((ir_q[11:9] & cc_q) != 3'b000) begin
                            pc_d = pc_off9;
                        end
                    end
                    OP_JMP: begin
                        pc_d = rf_a;
                    end
                    OP_JSR: begin
                        // Target uses BaseR before R7 is overwritten at this edge
                        pc_d     = ir_q[11] ? (pc_q + off11) : rf_a;
                        rf_we    = 1'b1;
                        rf_waddr = 3'd7;
                        rf_wdata = pc_q;
                    end
                    OP_TRAP: begin
                        mem_addr = trap_addr;
                        pc_d     = mem_rdata;
                        rf_we    = 1'b1;
                        rf_waddr = 3'd7;
                        rf_wdata = pc_q;
                        halt_d   = halt_q | trap_halt;
                    end
                    OP_LD, OP_ST, OP_LDI, OP_STI: begin
                        mar_d = pc_off9;
                    end
                    OP_LDR, OP_STR: begin
                        mar_d = rf_a + off6;
                    end
                    default: begin
                        // RTI and the reserved opcode retire without effect
                    end
                endcase

                if (is_ind_op(op)) begin
                    state_d = ST_IND;
                end else if (is_mem_op(op)) begin
                    state_d  = ST_MEM;
                    done_d   = 1'b1;
                    mem_we_d = is_store(op);
                end
            end

            ST_IND: begin
                mem_addr = mar_q;
                mar_d    = mem_rdata;
                state_d  = ST_MEM;
                done_d   = 1'b1;
                mem_we_d = is_store(op);
            end

            ST_MEM: begin
                mem_addr = mar_q;
                state_d  = ST_FETCH;
                if (is_load(op)) begin
                    rf_we    = 1'b1;
                    rf_wdata = mem_rdata;
                    set_cc   = 1'b1;
                end
            end

            default: begin
                state_d = ST_FETCH;
            end
        endcase

        if (set_cc) begin
            cc_d = cc_from(rf_wdata);
        end
    end

    // Architectural and control registers; reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mar_q    <= '0;
            cc_q     <= CC_RESET;
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            halt_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            mar_q    <= mar_d;
            cc_q     <= cc_d;
            mem_we_q <= mem_we_d;
            done_q   <= done_d;
            halt_q   <= halt_d;
        end
    end

    assign mem_wdata  = rf_b;
    assign mem_we     = mem_we_q;
    assign instr_done = done_q;
    assign pc_o       = pc_q;
    assign ir_o       = ir_q;
    assign cc_o       = cc_q;

endmodule

// File: tb/tb_lc3_control.sv
// tb/tb_lc3_control.sv - self-checking bench for lc3_control: vector table, corner sequences, random ISA model
module tb_lc3_control;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr, mem_rdata, mem_wdata;
    logic        mem_we, instr_done, halted;
    logic [15:0] pc_o, ir_o, dbg_reg;
    logic [2:0]  cc_o;
    logic [2:0]  dbg_sel = 3'd0;

    logic [15:0] mem [0:65535];

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0;

`ifdef LC3_TRAP_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    always #10 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    lc3_control #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_addr   (mem_addr),
        .mem_rdata  (mem_rdata),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .instr_done (instr_done),
        .pc_o       (pc_o),
        .ir_o       (ir_o),
        .cc_o       (cc_o),
        .dbg_sel    (dbg_sel),
        .dbg_reg    (dbg_reg),
        .halted     (halted)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_reg(input int r, output logic [15:0] v);
        dbg_sel = 3'(r);
        #1;
        v = dbg_reg;
    endtask

    // One clock; memory commits a write seen with mem_we high in that cycle
    task automatic tick();
        @(negedge clk);
        if (mem_we === 1'b1) begin
            mem[mem_addr] = mem_wdata;
            we_cnt++;
        end
    endtask

    task automatic run_instr(output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cyc++;
            if (instr_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout: no instr_done within %0d cycles", cyc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- ISA-level reference model ----------------
    logic [15:0] m_mem [0:65535];
    logic [15:0] m_reg [8];
    logic [15:0] m_pc, m_ir;
    logic [2:0]  m_cc;
    bit          m_halt;

    function automatic logic [15:0] sx(input logic [15:0] v, input int n);
        logic [15:0] mask;
        mask = 16'hFFFF << n;
        return v[n-1] ? (v | mask) : (v & ~mask);
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15]) return 3'b100;
        if (v == 16'h0000) return 3'b010;
        return 3'b001;
    endfunction

    task automatic model_step(output int lat);
        logic [15:0] ins, a, b, res, adr, tgt;
        int op, dr;
        ins  = m_mem[m_pc];
        m_ir = ins;
        m_pc = m_pc + 16'd1;
        op   = int'(ins[15:12]);
        dr   = int'(ins[11:9]);
        a    = m_reg[ins[8:6]];
        b    = ins[5] ? sx(ins, 5) : m_reg[ins[2:0]];
        lat  = 2;
        case (op)
            1:  begin res = a + b; m_reg[dr] = res; m_cc = cc_of(res); end
            5:  begin res = a & b; m_reg[dr] = res; m_cc = cc_of(res); end
            9:  begin res = ~a;    m_reg[dr] = res; m_cc = cc_of(res); end
            14: begin res = m_pc + sx(ins, 9); m_reg[dr] = res; m_cc = cc_of(res); end
            0:  if ((ins[11:9] & m_cc) != 3'b000) m_pc = m_pc + sx(ins, 9);
            12: m_pc = a;
            4:  begin
                    tgt = ins[11] ? m_pc + sx(ins, 11) : a;
                    m_reg[7] = m_pc;
                    m_pc = tgt;
                end
            15: begin
                    m_reg[7] = m_pc;
                    m_pc = m_mem[{8'h00, ins[7:0]}];
                    if (HALT_EN && ins[7:0] == 8'h25) m_halt = 1'b1;
                end
            2, 3, 6, 7, 10, 11: begin
                    adr = (op == 6 || op == 7) ? a + sx(ins, 6) : m_pc + sx(ins, 9);
                    lat = 3;
                    if (op == 10 || op == 11) begin
                        adr = m_mem[adr];
                        lat = 4;
                    end
                    if (op == 3 || op == 7 || op == 11) begin
                        m_mem[adr] = m_reg[dr];
                    end else begin
                        m_reg[dr] = m_mem[adr];
                        m_cc = cc_of(m_reg[dr]);
                    end
                end
            default: ;
        endcase
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        int          n;
        logic [15:0] p0, p1, p2;
        logic [15:0] a0, d0, a1, d1;
        int          rsel;
        logic [15:0] exp_r;
        logic [15:0] exp_pc;
        logic [2:0]  exp_cc;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string name, input int n,
                                input logic [15:0] p0, input logic [15:0] p1, input logic [15:0] p2,
                                input logic [15:0] a0, input logic [15:0] d0,
                                input logic [15:0] a1, input logic [15:0] d1,
                                input int rsel, input logic [15:0] exp_r, input logic [15:0] exp_pc,
                                input logic [2:0] exp_cc, input int exp_lat);
        vec_t v;
        v.name = name; v.n = n; v.p0 = p0; v.p1 = p1; v.p2 = p2;
        v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
        v.rsel = rsel; v.exp_r = exp_r; v.exp_pc = exp_pc; v.exp_cc = exp_cc; v.exp_lat = exp_lat;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cyc, lat, cnt, diffs;
        bit          ok;
        logic [15:0] v;
        logic [31:0] w;
        localparam logic [15:0] NA = 16'h7FFF;

        vecs.push_back(mk("add_imm",   1, 16'h1261, 16'h0000, 16'h0000, NA, 0, NA, 0, 1, 16'h0001, 16'h0001, 3'b001, 2));
        vecs.push_back(mk("add_neg",   2, 16'h5020, 16'h103F, 16'h0000, NA, 0, NA, 0, 0, 16'hFFFF, 16'h0002, 3'b100, 2));
        vecs.push_back(mk("brz_nt",    3, 16'h5020, 16'h103F, 16'h0400, NA, 0, NA, 0, 0, 16'hFFFF, 16'h0003, 3'b100, 2));
        vecs.push_back(mk("brn_t",     3, 16'h5020, 16'h103F, 16'h0801, NA, 0, NA, 0, 0, 16'hFFFF, 16'h0004, 3'b100, 2));
        vecs.push_back(mk("br_never",  1, 16'h0005, 16'h0000, 16'h0000, NA, 0, NA, 0, 0, 16'h0000, 16'h0001, 3'b010, 2));
        vecs.push_back(mk("ld",        1, 16'h2002, 16'h0000, 16'h0000, 16'h0003, 16'h8000, NA, 0, 0, 16'h8000, 16'h0001, 3'b100, 3));
        vecs.push_back(mk("ldi",       1, 16'hA404, 16'h0000, 16'h0000, 16'h0005, 16'h0020, 16'h0020, 16'h1234, 2, 16'h1234, 16'h0001, 3'b001, 4));
        vecs.push_back(mk("ldr_wrap",  1, 16'h6A3F, 16'h0000, 16'h0000, 16'hFFFF, 16'h8001, NA, 0, 5, 16'h8001, 16'h0001, 3'b100, 3));
        vecs.push_back(mk("lea_neg",   1, 16'hE7FE, 16'h0000, 16'h0000, NA, 0, NA, 0, 3, 16'hFFFF, 16'h0001, 3'b100, 2));
        vecs.push_back(mk("not_add_z", 3, 16'h5920, 16'h993F, 16'h1921, NA, 0, NA, 0, 4, 16'h0000, 16'h0003, 3'b010, 2));
        vecs.push_back(mk("add_reg",   3, 16'h5020, 16'h103F, 16'h1200, NA, 0, NA, 0, 1, 16'hFFFE, 16'h0003, 3'b100, 2));
        vecs.push_back(mk("and_imm",   3, 16'h5020, 16'h103F, 16'h502F, NA, 0, NA, 0, 0, 16'h000F, 16'h0003, 3'b001, 2));
        vecs.push_back(mk("jmp",       3, 16'h5020, 16'h103F, 16'hC000, NA, 0, NA, 0, 0, 16'hFFFF, 16'hFFFF, 3'b100, 2));
        vecs.push_back(mk("jsr",       1, 16'h4804, 16'h0000, 16'h0000, NA, 0, NA, 0, 7, 16'h0001, 16'h0005, 3'b010, 2));
        vecs.push_back(mk("trap",      1, 16'hF025, 16'h0000, 16'h0000, 16'h0025, 16'h0300, NA, 0, 7, 16'h0001, 16'h0300, 3'b010, 2));

        // Reset state
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 16'h1261;
        #3;
        chk("reset mem_we", mem_we, 1'b0);
        chk("reset instr_done", instr_done, 1'b0);
        release_reset();
        chk("reset pc", pc_o, 16'h0000);
        chk("reset ir", ir_o, 16'h0000);
        chk("reset cc", cc_o, 3'b010);
        chk("reset halted", halted, 1'b0);
        for (int r = 0; r < 8; r++) begin
            read_reg(r, v);
            chk($sformatf("reset R%0d", r), v, 16'h0000);
        end

        // Table-driven single programs
        foreach (vecs[i]) begin
            rst_n = 1'b0;
            clear_mem();
            mem[0] = vecs[i].p0; mem[1] = vecs[i].p1; mem[2] = vecs[i].p2;
            mem[vecs[i].a0] = vecs[i].d0;
            mem[vecs[i].a1] = vecs[i].d1;
            release_reset();
            for (int k = 0; k < vecs[i].n; k++) run_instr(cyc, ok);
            chk({vecs[i].name, " latency"}, cyc, vecs[i].exp_lat);
            chk({vecs[i].name, " pc"}, pc_o, vecs[i].exp_pc);
            chk({vecs[i].name, " cc"}, cc_o, vecs[i].exp_cc);
            read_reg(vecs[i].rsel, v);
            chk({vecs[i].name, " reg"}, v, vecs[i].exp_r);
        end

        // STR through R6+1
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 16'h2003; mem[1] = 16'h2C03; mem[2] = 16'h7181;
        mem[4] = 16'h8000; mem[5] = 16'h0010;
        release_reset();
        run_instr(cyc, ok);
        run_instr(cyc, ok);
        we_cnt = 0;
        run_instr(cyc, ok);
        chk("str latency", cyc, 3);
        chk("str mem[0011]", mem[16'h0011], 16'h8000);
        chk("str we cycles", we_cnt, 1);

        // STI through pointer at x0005
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 16'h14A7; mem[1] = 16'hB403; mem[5] = 16'h0020;
        release_reset();
        run_instr(cyc, ok);
        we_cnt = 0;
        run_instr(cyc, ok);
        chk("sti latency", cyc, 4);
        chk("sti mem[0020]", mem[16'h0020], 16'h0007);
        chk("sti we cycles", we_cnt, 1);

        // JSRR R7 jumps to old R7
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 16'hEE3F; mem[1] = 16'h41C0;
        release_reset();
        run_instr(cyc, ok);
        run_instr(cyc, ok);
        chk("jsrr pc", pc_o, 16'h0040);
        read_reg(7, v);
        chk("jsrr R7", v, 16'h0002);

        // TRAP x25 then observe whether the core keeps retiring
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 16'hF025; mem[16'h0025] = 16'h0300;
        release_reset();
        run_instr(cyc, ok);
        chk("trap25 pc", pc_o, 16'h0300);
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (instr_done === 1'b1) cnt++;
        end
        chk("trap25 later dones", cnt, HALT_EN ? 0 : 5);
        chk("trap25 halted", halted, HALT_EN);
        chk("trap25 pc after", pc_o, HALT_EN ? 16'h0300 : 16'h0305);

        // Reset asserted in the IND cycle of an LDI
        rst_n = 1'b0;
        clear_mem();
        mem[0] = 16'hA404; mem[5] = 16'h0020; mem[16'h0020] = 16'h1234;
        release_reset();
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort pc", pc_o, 16'h0000);
        chk("abort ir", ir_o, 16'h0000);
        chk("abort cc", cc_o, 3'b010);
        chk("abort mem_we", mem_we, 1'b0);
        chk("abort instr_done", instr_done, 1'b0);
        @(posedge clk);
        #1;
        read_reg(2, v);
        chk("abort R2", v, 16'h0000);
        rst_n = 1'b1;
        run_instr(cyc, ok);
        chk("abort rerun latency", cyc, 4);
        read_reg(2, v);
        chk("abort rerun R2", v, 16'h1234);

        // Random memory images executed against the ISA model
        for (int run = 0; run < 3; run++) begin
            rst_n = 1'b0;
            for (int a = 0; a < 65536; a++) begin
                w = $urandom;
                mem[a]   = w[15:0];
                m_mem[a] = w[15:0];
            end
            for (int r = 0; r < 8; r++) m_reg[r] = 16'h0000;
            m_pc = 16'h0000; m_cc = 3'b010; m_halt = 1'b0;
            release_reset();
            for (int k = 0; k < 300; k++) begin
                model_step(lat);
                run_instr(cyc, ok);
                if (!ok) break;
                chk($sformatf("rnd%0d.%0d latency", run, k), cyc, lat);
                chk($sformatf("rnd%0d.%0d pc", run, k), pc_o, m_pc);
                chk($sformatf("rnd%0d.%0d ir", run, k), ir_o, m_ir);
                chk($sformatf("rnd%0d.%0d cc", run, k), cc_o, m_cc);
                chk($sformatf("rnd%0d.%0d halted", run, k), halted, m_halt);
                for (int r = 0; r < 8; r++) begin
                    read_reg(r, v);
                    chk($sformatf("rnd%0d.%0d R%0d", run, k, r), v, m_reg[r]);
                end
                if (m_halt) break;
            end
            diffs = 0;
            for (int a = 0; a < 65536; a++) begin
                if (mem[a] !== m_mem[a]) diffs++;
            end
            chk($sformatf("rnd%0d memory image diffs", run), diffs, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lc3_control.md
Name: lc3_control

Overview:
- Multicycle LC-3 processor core: control FSM plus datapath (PC, IR, MAR, 8x16 register file, NZP condition codes, ALU, address adders).
- Sequences fetch/execute for the full LC-3 ISA through a single external memory port.
- Sits under the program-runner top level, which preloads memory and prints PC/IR/R0-R7/CC after each completed instruction.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_addr  out  16  memory word address.
- mem_rdata  in  16  read data; combinational from mem_addr, valid in the same cycle.
- mem_wdata  out  16  write data.
- mem_we  out  1  write strobe; memory writes on the clk edge while high.
- instr_done  out  1  one-cycle pulse in the final cycle of every instruction.
- pc_o  out  16  current PC.
- ir_o  out  16  current IR.
- cc_o  out  3  {N,Z,P}.
- dbg_sel  in  3  register-file debug select.
- dbg_reg  out  16  R[dbg_sel], combinational.
- halted  out  1  halt status; constant 0 unless LC3_TRAP_HALT_EN.

Behaviour:
- Reset (async, rst_n low):
  - PC=RESET_PC, IR=0, MAR=0, R0-R7=0, CC=3'b010.
  - State=FETCH; mem_we=0, instr_done=0, halted=0.
  - Reset mid-instruction aborts it; no partial register or memory write after release.
- States are FETCH, EXEC, IND, MEM.
- FETCH: mem_addr=PC; IR<=mem_rdata; PC<=PC+1 (wraps xFFFF->x0000); go to EXEC.
- EXEC decodes IR[15:12]. PC below means the already-incremented PC. Offsets are sign-extended; imm5 is sign-extended; trapvect8 is zero-extended.
  - ADD/AND: DR<=SR1 op (IR[5] ? imm5 : SR2). NOT: DR<=~SR1. All 16-bit, carry discarded.
  - BR: if (IR[11:9] & CC)!=0, PC<=PC+off9. nzp=000 never branches.
  - JMP/RET: PC<=BaseR.
  - JSR/JSRR: target=PC+off11 (IR[11]=1) or BaseR, using BaseR's old value; then R7<=PC, PC<=target. JSRR R7 jumps to old R7.
  - LEA: DR<=PC+off9.
  - TRAP: mem_addr=zext(trapvect8); R7<=PC; PC<=mem_rdata.
  - LD/ST/LDI/STI: MAR<=PC+off9. LDR/STR: MAR<=BaseR+off6.
  - LD/LDR/ST/STR go to MEM; LDI/STI go to IND. All others pulse instr_done and go to FETCH.
  - RTI (1000) and reserved (1101) execute as NOPs.
- IND: mem_addr=MAR; MAR<=mem_rdata; go to MEM.
- MEM: mem_addr=MAR.
  - Loads: DR<=mem_rdata.
  - Stores: mem_wdata=SR (IR[11:9]), mem_we=1.
  - Pulse instr_done; go to FETCH.
- Latency: 2 cycles for non-memory instructions, 3 for LD/LDR/ST/STR, 4 for LDI/STI.
- CC update, in the cycle DR is written, from the 16-bit result:
  - Applies to ADD, AND, NOT, LEA, LD, LDR, LDI.
  - N=bit15, Z=(result==0), P=otherwise; exactly one bit set.
  - Other instructions leave CC unchanged.
- mem_we is high only in a store's MEM cycle.
- pc_o, ir_o and cc_o reflect registered values.

Optional Feature:
- Macro LC3_TRAP_HALT_EN.
- Defined: TRAP x25 sets R7 and PC like any trap, then sets halted=1 and holds in FETCH without fetching or asserting instr_done until reset. instr_done still pulses for the TRAP itself.
- Undefined: TRAP x25 is an ordinary trap; halted is tied 0.

Decomposition:
- Package lc3_pkg: opcode enum (ADD=0001 … TRAP=1111), FSM state enum, word width 16, CC reset constant 3'b010.
- Sub-module lc3_regfile: 8x16, two async read ports plus debug read, one synchronous write, async active-low clear.

Test Plan:
- Reset: PC=x0000, CC=010. Mem[0]=x1261 (ADD R1,R1,#1) -> after instr_done, R1=x0001, PC=x0001, CC=001; 2 cycles.
- Mem[0]=x5020 (AND R0,R0,#0), Mem[1]=x103F (ADD R0,R0,#-1) -> R0=xFFFF, CC=100. Then x0400 (BRz) not taken; x0801 (BRn +1) taken, PC=x0004.
- Mem[0]=x2002 (LD R0,+2), Mem[3]=x8000 -> R0=x8000, CC=100, 3 cycles. STR R0 to R6+1 with R6=x0010 -> mem[x0011]=x8000, mem_we high for exactly 1 cycle.
- LDI with pointer mem[x0005]=x0020, mem[x0020]=x1234 -> DR=x1234, CC=001, 4 cycles. STI of the same layout writes to x0020.
- JSR +4 at x0000 -> R7=x0001, PC=x0005. JSRR R7 with R7=x0040 -> PC=x0040, R7=old PC+1.
- TRAP x25 with mem[x0025]=x0300 -> R7=PC+1, PC=x0300. With LC3_TRAP_HALT_EN, halted=1 and no further instr_done.
- Assert rst_n low during the IND state of an LDI -> all state is back at reset values and no register write occurs.
